// File: rtl/decode_buffer_if.sv
// decode_buffer_if: fetch-to-decode-buffer entry handshake.
// master = fetch side, slave = decode buffer.
interface decode_buffer_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_inst;
   logic        in_exc;
   logic [4:0]  in_exccode;

   modport master (
      output in_valid,
      output in_pc,
      output in_inst,
      output in_exc,
      output in_exccode,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_pc,
      input  in_inst,
      input  in_exc,
      input  in_exccode,
      output in_ready
   );
endinterface

// File: rtl/decode_buffer.sv
// decode_buffer: instruction FIFO, operand fetch with prioritised forwarding,
// target calculation and registered issue. Define DECODE_BUFFER_BYPASS_EN to
// let an entry arriving at an empty FIFO issue in the same cycle.
module decode_buffer #(
   parameter int DEPTH = 4,
   parameter int NFWD  = 2
) (
   input  logic                    clk,
   input  logic                    resetn,
   decode_buffer_if.slave          fe,
   input  logic                    flush_i,
   output logic [4:0]              rf_raddr1,
   output logic [4:0]              rf_raddr2,
   input  logic [31:0]             rf_rdata1,
   input  logic [31:0]             rf_rdata2,
   input  logic [NFWD*5-1:0]       fwd_addr,
   input  logic [NFWD*32-1:0]      fwd_data,
   input  logic [NFWD-1:0]         fwd_ok,
   output logic                    valid_o,
   input  logic                    ready_i,
   output logic [31:0]             pc_o,
   output logic [31:0]             inst_o,
   output logic [31:0]             rdata1_o,
   output logic [31:0]             rdata2_o,
   output logic [31:0]             pc_j_o,
   output logic [31:0]             pc_b_o,
   output logic                    exc_o,
   output logic [4:0]              exccode_o,
   output logic [$clog2(DEPTH):0]  count_o,
   output logic [31:0]             perfcnt_fwd_stall
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   mem_pc   [DEPTH];
   logic [31:0]   mem_inst [DEPTH];
   logic          mem_exc  [DEPTH];
   logic [4:0]    mem_code [DEPTH];
   logic [AW-1:0] rptr;
   logic [AW-1:0] wptr;

   logic          head_present;
   logic          byp;
   logic [31:0]   h_pc;
   logic [31:0]   h_inst;
   logic          h_exc;
   logic [4:0]    h_code;
   logic [31:0]   op1;
   logic [31:0]   op2;
   logic          st1;
   logic          st2;
   logic          stall;
   logic          issue;
   logic          push;
   logic          pop;
   logic [31:0]   pc4;
   logic [31:0]   pc_b;
   logic [31:0]   pc_j;

   // Head entry: slot at rptr, or the incoming entry when bypassing
   always_comb begin
      head_present = (count_o != '0);
      h_pc         = mem_pc[rptr];
      h_inst       = mem_inst[rptr];
      h_exc        = mem_exc[rptr];
      h_code       = mem_code[rptr];
      byp          = 1'b0;
`ifdef DECODE_BUFFER_BYPASS_EN
      if (count_o == '0 && fe.in_valid) begin
         byp          = 1'b1;
         head_present = 1'b1;
         h_pc         = fe.in_pc;
         h_inst       = fe.in_inst;
         h_exc        = fe.in_exc;
         h_code       = fe.in_exccode;
      end
`endif
   end

   assign rf_raddr1 = head_present ? h_inst[25:21] : 5'd0;
   assign rf_raddr2 = head_present ? h_inst[20:16] : 5'd0;

   // Operand select: scan oldest to youngest so the lowest-index hit wins
   always_comb begin
      op1 = rf_rdata1;
      op2 = rf_rdata2;
      st1 = 1'b0;
      st2 = 1'b0;
      for (int i = NFWD - 1; i >= 0; i--) begin
         if (rf_raddr1 != 5'd0 &&
             rf_raddr1 == fwd_addr[i*5 +: 5]) begin
            op1 = fwd_data[i*32 +: 32];
            st1 = !fwd_ok[i];
         end
         if (rf_raddr2 != 5'd0 &&
             rf_raddr2 == fwd_addr[i*5 +: 5]) begin
            op2 = fwd_data[i*32 +: 32];
            st2 = !fwd_ok[i];
         end
      end
   end

   assign stall = st1 || st2;
   assign issue = head_present && (!stall || h_exc)
                  && (!valid_o || ready_i) && !flush_i;
   assign pop   = issue && !byp;

   assign fe.in_ready = (count_o < CW'(DEPTH));
   assign push = fe.in_valid && fe.in_ready && !flush_i
                 && !(byp && issue);

   assign pc4  = h_pc + 32'd4;
   assign pc_b = pc4 + {{14{h_inst[15]}}, h_inst[15:0], 2'b00};
   assign pc_j = {pc4[31:28], h_inst[25:0], 2'b00};

   // Entry storage; contents are only meaningful under the occupancy count
   always_ff @(posedge clk) begin
      if (push) begin
         mem_pc[wptr]   <= fe.in_pc;
         mem_inst[wptr] <= fe.in_inst;
         mem_exc[wptr]  <= fe.in_exc;
         mem_code[wptr] <= fe.in_exccode;
      end
   end

   // Pointers and occupancy; a flush empties the FIFO
   always_ff @(posedge clk) begin
      if (!resetn || flush_i) begin
         rptr    <= '0;
         wptr    <= '0;
         count_o <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         count_o <= count_o + CW'(push) - CW'(pop);
      end
   end

   // Issue register: load on issue, hold under backpressure
   always_ff @(posedge clk) begin
      if (!resetn) begin
         valid_o   <= 1'b0;
         pc_o      <= '0;
         inst_o    <= '0;
         rdata1_o  <= '0;
         rdata2_o  <= '0;
         pc_j_o    <= '0;
         pc_b_o    <= '0;
         exc_o     <= 1'b0;
         exccode_o <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (issue) begin
         valid_o   <= 1'b1;
         pc_o      <= h_pc;
         inst_o    <= h_inst;
         rdata1_o  <= op1;
         rdata2_o  <= op2;
         pc_j_o    <= pc_j;
         pc_b_o    <= pc_b;
         exc_o     <= h_exc;
         exccode_o <= h_code;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

   // Count cycles a head waits on an unavailable forwarded operand
   always_ff @(posedge clk) begin
      if (!resetn) begin
         perfcnt_fwd_stall <= '0;
      end else if (head_present && stall && !h_exc) begin
         perfcnt_fwd_stall <= perfcnt_fwd_stall + 32'd1;
      end
   end
endmodule

// File: doc/decode_buffer.md
# decode_buffer

Instruction buffer and operand-fetch stage placed between fetch and execute. Decouples instruction-memory responses from back-end stalls. Incoming instructions are stored in a `DEPTH`-entry FIFO. For the head entry, the block reads the register file, resolves operands from `NFWD` prioritised forwarding sources, computes branch and jump targets, and issues into a registered output bundle with a valid/ready handshake.

## Interface

**Parameters**

- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `NFWD`, default 2: number of forwarding sources. Index 0 is the youngest and has the highest priority.

**Ports** (name, direction, width, meaning)

- `clk` in 1: clock.
- `resetn` in 1: synchronous, active-low reset.
- `in_valid` in 1: fetch delivers an entry.
- `in_ready` out 1: FIFO can accept an entry.
- `in_pc` in 32: PC of the incoming instruction.
- `in_inst` in 32: instruction word.
- `in_exc` in 1: fetch-side exception flag.
- `in_exccode` in 5: fetch-side exception code.
- `flush_i` in 1: discard all buffered and issued-but-unaccepted work.
- `rf_raddr1` out 5: register-file read address = rs of the head entry.
- `rf_raddr2` out 5: register-file read address = rt of the head entry.
- `rf_rdata1` in 32: register-file read data for `rf_raddr1`.
- `rf_rdata2` in 32: register-file read data for `rf_raddr2`.
- `fwd_addr` in `NFWD*5`: forwarding destination registers; 0 means no write.
- `fwd_data` in `NFWD*32`: forwarding values.
- `fwd_ok` in `NFWD`: forwarding value is available this cycle.
- `valid_o` out 1: output bundle valid.
- `ready_i` in 1: downstream accepts the bundle.
- `pc_o` out 32: issued PC.
- `inst_o` out 32: issued instruction.
- `rdata1_o` out 32: resolved rs operand.
- `rdata2_o` out 32: resolved rt operand.
- `pc_j_o` out 32: jump target.
- `pc_b_o` out 32: branch target.
- `exc_o` out 1: issued exception flag.
- `exccode_o` out 5: issued exception code.
- `count_o` out `$clog2(DEPTH)+1`: current FIFO occupancy.
- `perfcnt_fwd_stall` out 32: forwarding-stall cycle counter.

## Operation

**FIFO**

- Each entry holds `{pc, inst, exc, exccode}`.
- Read and write pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Occupancy is a separate counter.
- `in_ready = (count < DEPTH)`. A pop in the same cycle does not free a slot, so a full FIFO does not accept a simultaneous push.
- Push occurs when `in_valid && in_ready && !flush_i`.

**Head selection and forwarding**

- The head is the FIFO entry at the read pointer. `rf_raddr1` and `rf_raddr2` are driven from its `inst[25:21]` and `inst[20:16]`.
- Source i hits operand k when `raddr_k != 0 && raddr_k == fwd_addr[i]`.
- The lowest-index hit supplies the operand. With no hit, the operand comes from `rf_rdata`. Register 0 always yields the register-file value.
- `stall` is asserted if, for either operand, the selected (lowest-index) hit has `fwd_ok = 0`. A lower-priority source being ready does not clear the stall.

**Issue**

- `issue = head_present && (!stall || head.exc) && (!valid_o || ready_i) && !flush_i`.
- On issue: pop the head and load the output registers with the head fields, resolved operands, and targets.
- Targets:
  - `pc_b = pc + 4 + {{14{imm[15]}}, imm, 2'b00}`, with imm = `inst[15:0]`. Arithmetic is modulo 2^32.
  - `pc_j = {(pc+4)[31:28], inst[25:0], 2'b00}`.
- Output hold: while `valid_o && !ready_i`, every output register is frozen.
- `valid_o` falls after acceptance when no new issue occurs in the same cycle.

**Flush**

- `flush_i` clears both pointers, the occupancy count, and `valid_o` on the next edge.
- It blocks any same-cycle push and issue.
- It overrides `ready_i`.

**Performance counter**

- `perfcnt_fwd_stall` increments when `head_present && stall && !head.exc`.
- It wraps at 2^32 and is not cleared by flush.

**Reset**

- Applies when `resetn = 0` at a clock edge.
- All output registers, pointers, the count, and the counter go to 0.
- After reset, `in_ready = 1`, `rf_raddr1 = rf_raddr2 = 0`, and `count_o = 0`.

## Timing

- Base latency: push at edge t, head visible after t, `valid_o` high after edge t+1 (2 cycles).
- Throughput: 1 issue per cycle while the FIFO is non-empty, there is no stall, and `ready_i` is high.
- Forwarding compare and select are combinational from the head entry. Operands are sampled at the issue edge.
- `in_ready` depends only on registered state and has no combinational path from `ready_i`.

## Configuration

- **`DECODE_BUFFER_BYPASS_EN` defined:**
  - When the FIFO is empty and `in_valid` is high, the incoming entry acts as the head in the same cycle and may issue directly. In that case it is not written.
  - Latency becomes 1 cycle.
  - If the bypassed entry cannot issue, it is pushed normally.
- **Undefined:** all entries pass through FIFO storage, and latency is 2 cycles.

## Test plan

1. **Streaming, no bypass:** reset, then push PCs 0x100, 0x104, 0x108 on consecutive cycles with `ready_i = 1`. Required: `valid_o` on cycles 2–4 with matching `pc_o`, and `pc_b_o = pc + 4` for `imm = 0`.
2. **Full FIFO and backpressure:** `DEPTH = 4`, `ready_i = 0`, push 6 entries. Required: `in_ready = 0` once `count_o = 4`, and `pc_o` held. Releasing `ready_i` drains the entries in order.
3. **Forwarding priority:** head rs = 5, `fwd_addr[0] = 5` with `ok = 1` and data 0xAAAA, `fwd_addr[1] = 5` with data 0xBBBB. Required: `rdata1_o = 0xAAAA`. Then set `fwd_ok[0] = 0`: stall holds, and `perfcnt_fwd_stall` increments each cycle.
4. **Register 0 and exception:** rs = 0 with `fwd_addr[0] = 0` gives the register-file value. A head with `exc = 1` whose operand has a not-ready hit issues anyway, with `exccode_o` passed through.
5. **Flush:** 3 entries buffered, `valid_o = 1`, `flush_i` pulsed together with `in_valid`. Required next cycle: `valid_o = 0`, `count_o = 0`, and the incoming entry dropped.
6. **Targets and wrap:** `pc = 0xFFFFFFFC`, `imm = 0xFFFF` gives `pc_b_o = 0xFFFFFFFC`. `pc = 0x8FFFFFFC`, index `0x3FFFFFF` gives `pc_j_o = 0x9FFFFFFC`.
